redas_pe_mw: RTL and testbench

Multi-weight, handshaked successor of the ReDAS roundabout processing element. It keeps the reconfigurable crossbar datapath (weight, output or input stationary, with right-angle movement) and adds a STAT_DEPTH-entry stationary bank with an auto-indexing pointer. It also adds a valid-qualified, fully registered beat pipeline, a config shadow register loaded by a ready/valid handshake, and optional saturating MAC. It is tiled inside the roundabout systolic array, one instance per grid node.

---
 rtl/redas_pe_mw.sv | 141 ++++++++++++++
 tb/tb_redas_pe_mw.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/redas_pe_mw.sv
// redas_pe_mw: multi-weight roundabout processing element.
// Reconfigurable crossbar datapath with a stationary bank, a registered beat
// pipeline and a handshaked config shadow register.
module redas_pe_mw #(
  parameter int DATA_WIDTH = 8,
  parameter int STAT_DEPTH = 4,
  parameter int SATURATE   = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_WIDTH-1:0]         in_from_left,
  input  logic [DATA_WIDTH-1:0]         in_from_right,
  input  logic [DATA_WIDTH-1:0]         in_from_top,
  input  logic [DATA_WIDTH-1:0]         in_from_bottom,
  input  logic                          in_valid,
  input  logic                          store_stationary,
  input  logic                          stat_ptr_clr,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [3:0]                    cfg_movement,
  input  logic [4:0]                    cfg_pattern,
  input  logic                          cfg_right_angle,
  input  logic                          cfg_auto_inc,
  output logic [DATA_WIDTH-1:0]         out_to_left,
  output logic [DATA_WIDTH-1:0]         out_to_right,
  output logic [DATA_WIDTH-1:0]         out_to_top,
  output logic [DATA_WIDTH-1:0]         out_to_bottom,
  output logic                          out_valid,
  output logic                          sat_flag,
  output logic [$clog2(STAT_DEPTH)-1:0] stat_ptr
);
  localparam int PW = $clog2(STAT_DEPTH);
  localparam int FW = 2 * DATA_WIDTH + 1;

  // Config shadow registers
  logic [3:0] mv;
  logic [4:0] pt;
  logic       right_angle;
  logic       auto_inc;

  logic signed [DATA_WIDTH-1:0] bank [STAT_DEPTH];

  logic signed [DATA_WIDTH-1:0] ha, hb, va, vb, p, q, m1, m2, bk;
  logic signed [DATA_WIDTH-1:0] mac, xa, xb, bot_a, bot_b, rgt_a, rgt_b;
  logic signed [FW-1:0]         mac_full;
  logic [DATA_WIDTH+1:0]        top_bits;
  logic                         ovf;
  logic [DATA_WIDTH-1:0]        nxt_left, nxt_right, nxt_top, nxt_bottom;
  logic                         beat, cfg_xfer;

  assign cfg_ready = !in_valid;
  assign cfg_xfer  = cfg_valid && cfg_ready;
  assign beat      = in_valid;
  assign bk        = bank[stat_ptr];

  // Crossbar datapath and MAC for the current beat
  always_comb begin
    ha = mv[0] ? $signed(in_from_left)   : $signed(in_from_right);
    hb = mv[0] ? $signed(in_from_right)  : $signed(in_from_left);
    va = mv[1] ? $signed(in_from_bottom) : $signed(in_from_top);
    vb = mv[1] ? $signed(in_from_top)    : $signed(in_from_bottom);
    p  = pt[0] ? ha : va;
    q  = pt[0] ? va : ha;
    m1 = pt[1] ? q  : bk;
    m2 = pt[1] ? bk : q;
    mac_full = FW'(p) * FW'(m1) + FW'(m2);
    // Result fits in DATA_WIDTH only when all bits from the sign down agree
    top_bits = mac_full[FW-1:DATA_WIDTH-1];
    ovf = !((&top_bits) || !(|top_bits));
    if ((SATURATE != 0) && ovf)
      mac = mac_full[FW-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                           : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else
      mac = mac_full[DATA_WIDTH-1:0];
    xa    = pt[2] ? p   : mac;
    xb    = pt[2] ? mac : p;
    bot_a = pt[3] ? va  : xa;
    rgt_a = pt[4] ? ha  : xb;
    bot_b = right_angle ? hb : vb;
    rgt_b = right_angle ? vb : hb;
    nxt_right  = mv[2] ? rgt_a : rgt_b;
    nxt_left   = mv[2] ? rgt_b : rgt_a;
    nxt_top    = mv[3] ? bot_a : bot_b;
    nxt_bottom = mv[3] ? bot_b : bot_a;
  end

  // Config shadow load on handshake; sticky overflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mv          <= 4'b1111;
      pt          <= 5'b00111;
      right_angle <= 1'b0;
      auto_inc    <= 1'b0;
      sat_flag    <= 1'b0;
    end else begin
      if (cfg_xfer) begin
        mv          <= cfg_movement;
        pt          <= cfg_pattern;
        right_angle <= cfg_right_angle;
        auto_inc    <= cfg_auto_inc;
        sat_flag    <= 1'b0;
      end else if (beat && (SATURATE != 0) && ovf) begin
        sat_flag <= 1'b1;
      end
    end
  end

  // Output registers, loaded only on a beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_to_left   <= '0;
      out_to_right  <= '0;
      out_to_top    <= '0;
      out_to_bottom <= '0;
      out_valid     <= 1'b0;
    end else begin
      out_valid <= beat;
      if (beat) begin
        out_to_left   <= nxt_left;
        out_to_right  <= nxt_right;
        out_to_top    <= nxt_top;
        out_to_bottom <= nxt_bottom;
      end
    end
  end

  // Stationary bank write and pointer; write uses the pre-edge index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < STAT_DEPTH; i++) bank[i] <= '0;
      stat_ptr <= '0;
    end else begin
      if (beat && store_stationary) bank[stat_ptr] <= mac;
      if (stat_ptr_clr)
        stat_ptr <= '0;
      else if (beat && store_stationary && auto_inc)
        stat_ptr <= stat_ptr + PW'(1);
    end
  end

endmodule

// File: tb/tb_redas_pe_mw.sv
// Self-checking bench for redas_pe_mw: a saturating and a truncating
// instance share stimulus; a spec-level model feeds a scoreboard queue.
module tb_redas_pe_mw;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] in_l = '0, in_r = '0, in_t = '0, in_b = '0;
  logic in_valid = 1'b0, store = 1'b0, clr = 1'b0;
  logic cfg_valid = 1'b0;
  logic [3:0] cfg_mv = 4'b1111;
  logic [4:0] cfg_pt = 5'b00111;
  logic cfg_ra = 1'b0, cfg_ai = 1'b0;

  logic [7:0] s_left, s_right, s_top, s_bot, t_left, t_right, t_top, t_bot;
  logic s_valid, t_valid, s_sat, t_sat, s_ready, t_ready;
  logic [1:0] s_ptr, t_ptr;

  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  redas_pe_mw #(.DATA_WIDTH(8), .STAT_DEPTH(4), .SATURATE(1)) dut_s (
    .clk(clk), .rst_n(rst_n),
    .in_from_left(in_l), .in_from_right(in_r), .in_from_top(in_t), .in_from_bottom(in_b),
    .in_valid(in_valid), .store_stationary(store), .stat_ptr_clr(clr),
    .cfg_valid(cfg_valid), .cfg_ready(s_ready),
    .cfg_movement(cfg_mv), .cfg_pattern(cfg_pt), .cfg_right_angle(cfg_ra), .cfg_auto_inc(cfg_ai),
    .out_to_left(s_left), .out_to_right(s_right), .out_to_top(s_top), .out_to_bottom(s_bot),
    .out_valid(s_valid), .sat_flag(s_sat), .stat_ptr(s_ptr));

  redas_pe_mw #(.DATA_WIDTH(8), .STAT_DEPTH(4), .SATURATE(0)) dut_t (
    .clk(clk), .rst_n(rst_n),
    .in_from_left(in_l), .in_from_right(in_r), .in_from_top(in_t), .in_from_bottom(in_b),
    .in_valid(in_valid), .store_stationary(store), .stat_ptr_clr(clr),
    .cfg_valid(cfg_valid), .cfg_ready(t_ready),
    .cfg_movement(cfg_mv), .cfg_pattern(cfg_pt), .cfg_right_angle(cfg_ra), .cfg_auto_inc(cfg_ai),
    .out_to_left(t_left), .out_to_right(t_right), .out_to_top(t_top), .out_to_bottom(t_bot),
    .out_valid(t_valid), .sat_flag(t_sat), .stat_ptr(t_ptr));

  typedef struct {
    logic signed [7:0] r, l, t, b, mac;
    bit ovf;
  } res_t;

  typedef struct {
    res_t s;
    res_t t;
    logic [1:0] ptr;
    bit satf;
  } exp_t;

  exp_t sb[$];

  // Reference model state
  logic [3:0] m_mv;
  logic [4:0] m_pt;
  bit m_ra, m_ai, m_sat;
  logic [1:0] m_ptr;
  logic signed [7:0] m_bank_s [4];
  logic signed [7:0] m_bank_t [4];
  logic [31:0] m_last;

  task automatic model_reset();
    m_mv = 4'b1111; m_pt = 5'b00111; m_ra = 0; m_ai = 0; m_sat = 0; m_ptr = '0;
    for (int i = 0; i < 4; i++) begin m_bank_s[i] = '0; m_bank_t[i] = '0; end
    m_last = '0;
    sb.delete();
  endtask

  function automatic res_t compute(input bit sat_en, input logic signed [7:0] l, r, t, bo, bk);
    res_t o;
    logic signed [7:0] ha, hb, va, vb, p, q, m1, m2, xa, xb, ba, bb, ra_, rb;
    int full;
    ha = m_mv[0] ? l : r;   hb = m_mv[0] ? r : l;
    va = m_mv[1] ? bo : t;  vb = m_mv[1] ? t : bo;
    p  = m_pt[0] ? ha : va; q  = m_pt[0] ? va : ha;
    m1 = m_pt[1] ? q : bk;  m2 = m_pt[1] ? bk : q;
    full = int'(p) * int'(m1) + int'(m2);
    o.ovf = (full > 127) || (full < -128);
    if (sat_en && full > 127) o.mac = 8'h7f;
    else if (sat_en && full < -128) o.mac = 8'h80;
    else o.mac = full[7:0];
    xa = m_pt[2] ? p : o.mac;  xb = m_pt[2] ? o.mac : p;
    ba = m_pt[3] ? va : xa;    ra_ = m_pt[4] ? ha : xb;
    bb = m_ra ? hb : vb;       rb = m_ra ? vb : hb;
    o.r = m_mv[2] ? ra_ : rb;  o.l = m_mv[2] ? rb : ra_;
    o.t = m_mv[3] ? ba : bb;   o.b = m_mv[3] ? bb : ba;
    return o;
  endfunction

  // Drive one beat, push its expectation, then pop and compare after the edge
  task automatic beat(input logic [7:0] l, r, t, bo, input bit st, input bit cl);
    exp_t e;
    exp_t g;
    e.s = compute(1'b1, l, r, t, bo, m_bank_s[m_ptr]);
    e.t = compute(1'b0, l, r, t, bo, m_bank_t[m_ptr]);
    if (e.s.ovf) m_sat = 1;
    if (st) begin m_bank_s[m_ptr] = e.s.mac; m_bank_t[m_ptr] = e.t.mac; end
    if (cl) m_ptr = '0;
    else if (st && m_ai) m_ptr = m_ptr + 2'd1;
    e.ptr = m_ptr; e.satf = m_sat;
    sb.push_back(e);
    in_l = l; in_r = r; in_t = t; in_b = bo;
    store = st; clr = cl; in_valid = 1'b1;
    @(posedge clk); #1;
    g = sb.pop_front();
    m_last = {g.s.r, g.s.l, g.s.t, g.s.b};
    n_tests++;
    if ({s_right, s_left, s_top, s_bot} !== m_last) begin
      n_fail++; $display("FAIL beat_outputs got=%h exp=%h", {s_right, s_left, s_top, s_bot}, m_last);
    end
    n_tests++;
    if (t_right !== g.t.r) begin
      n_fail++; $display("FAIL beat_trunc_right got=%h exp=%h", t_right, g.t.r);
    end
    n_tests++;
    if ({s_valid, t_valid} !== 2'b11) begin
      n_fail++; $display("FAIL beat_out_valid got=%b exp=11", {s_valid, t_valid});
    end
    n_tests++;
    if (s_ptr !== g.ptr || t_ptr !== g.ptr) begin
      n_fail++; $display("FAIL beat_stat_ptr got=%0d/%0d exp=%0d", s_ptr, t_ptr, g.ptr);
    end
    n_tests++;
    if ({s_sat, t_sat} !== {g.satf, 1'b0}) begin
      n_fail++; $display("FAIL beat_sat_flag got=%b exp=%b0", {s_sat, t_sat}, g.satf);
    end
  endtask

  task automatic idle_check();
    in_valid = 1'b0; store = 1'b0; clr = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (s_valid !== 1'b0 || {s_right, s_left, s_top, s_bot} !== m_last) begin
      n_fail++; $display("FAIL idle_hold got=%b/%h exp=0/%h", s_valid, {s_right, s_left, s_top, s_bot}, m_last);
    end
  endtask

  task automatic cfg_cycle(input logic [3:0] mv, input logic [4:0] pt, input bit ra, input bit ai);
    in_valid = 1'b0; store = 1'b0; clr = 1'b0;
    cfg_mv = mv; cfg_pt = pt; cfg_ra = ra; cfg_ai = ai; cfg_valid = 1'b1;
    #1;
    n_tests++;
    if (s_ready !== 1'b1) begin
      n_fail++; $display("FAIL cfg_ready_idle got=%b exp=1", s_ready);
    end
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    m_mv = mv; m_pt = pt; m_ra = ra; m_ai = ai; m_sat = 0;
    n_tests++;
    if (s_sat !== 1'b0) begin
      n_fail++; $display("FAIL cfg_clears_sat got=%b exp=0", s_sat);
    end
  endtask

  task automatic test_reset();
    model_reset();
    #12;
    n_tests++;
    if ({s_right, s_left, s_top, s_bot, s_valid, s_sat, s_ptr} !== '0) begin
      n_fail++; $display("FAIL reset_state got=%h exp=0", {s_right, s_left, s_top, s_bot, s_valid, s_sat, s_ptr});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    beat(8'd5, 8'd7, 8'd9, 8'd6, 1'b0, 1'b0);
    n_tests++;
    if (s_right !== 8'd30 || s_top !== 8'd5) begin
      n_fail++; $display("FAIL basic_mac got=%0d/%0d exp=30/5", s_right, s_top);
    end
    idle_check();
  endtask

  task automatic test_store();
    beat(8'd5, 8'd0, 8'd0, 8'd6, 1'b1, 1'b0);
    n_tests++;
    if (s_right !== 8'd30) begin
      n_fail++; $display("FAIL store_reads_old got=%0d exp=30", s_right);
    end
    beat(8'd2, 8'd0, 8'd0, 8'd3, 1'b0, 1'b0);
    n_tests++;
    if (s_right !== 8'd36) begin
      n_fail++; $display("FAIL store_visible got=%0d exp=36", s_right);
    end
    idle_check();
  endtask

  task automatic test_midstream_reset();
    cfg_cycle(4'b0000, 5'b11111, 1'b1, 1'b1);
    beat(8'd3, 8'd4, 8'd5, 8'd6, 1'b1, 1'b0);
    beat(8'd7, 8'd8, 8'd9, 8'd10, 1'b0, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({s_right, s_left, s_top, s_bot, s_valid, s_sat, s_ptr} !== '0) begin
      n_fail++; $display("FAIL async_reset got=%h exp=0", {s_right, s_left, s_top, s_bot, s_valid, s_sat, s_ptr});
    end
    in_valid = 1'b0;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    beat(8'd5, 8'd0, 8'd0, 8'd6, 1'b0, 1'b0);
    n_tests++;
    if (s_right !== 8'd30 || s_top !== 8'd5) begin
      n_fail++; $display("FAIL reset_cfg_bank got=%0d/%0d exp=30/5", s_right, s_top);
    end
    idle_check();
  endtask

  task automatic test_saturate();
    beat(8'd100, 8'd0, 8'd0, 8'd100, 1'b0, 1'b0);
    n_tests++;
    if (s_right !== 8'h7f || t_right !== 8'd16 || s_sat !== 1'b1) begin
      n_fail++; $display("FAIL sat_pos got=%h/%h/%b exp=7f/10/1", s_right, t_right, s_sat);
    end
    beat(8'h9c, 8'd0, 8'd0, 8'd100, 1'b0, 1'b0);
    n_tests++;
    if (s_right !== 8'h80) begin
      n_fail++; $display("FAIL sat_neg got=%h exp=80", s_right);
    end
    idle_check();
  endtask

  task automatic test_auto_inc();
    logic [7:0] rd [5];
    rd[0] = 8'd2; rd[1] = 8'd3; rd[2] = 8'd4; rd[3] = 8'd5; rd[4] = 8'd2;
    // mac = left*bank + bottom, so left=0 stores bottom and left=1,bottom=0 rewrites bank as-is
    cfg_cycle(4'b1111, 5'b00101, 1'b0, 1'b1);
    for (int v = 1; v <= 5; v++) beat(8'd0, 8'd0, 8'd0, 8'(v), 1'b1, 1'b0);
    n_tests++;
    if (s_ptr !== 2'd1) begin
      n_fail++; $display("FAIL ptr_wrap got=%0d exp=1", s_ptr);
    end
    for (int k = 0; k < 5; k++) begin
      beat(8'd1, 8'd0, 8'd0, 8'd0, 1'b1, k == 4);
      n_tests++;
      if (s_right !== rd[k]) begin
        n_fail++; $display("FAIL bank_read%0d got=%0d exp=%0d", k, s_right, rd[k]);
      end
    end
    n_tests++;
    if (s_ptr !== 2'd0) begin
      n_fail++; $display("FAIL ptr_clr got=%0d exp=0", s_ptr);
    end
    idle_check();
  endtask

  task automatic test_cfg_during_beat();
    cfg_cycle(4'b1111, 5'b00111, 1'b0, 1'b0);
    cfg_mv = 4'b0000; cfg_pt = 5'b11010; cfg_ra = 1'b1; cfg_ai = 1'b0; cfg_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      beat(8'd100, 8'(k + 1), 8'(k + 2), 8'd100, 1'b0, 1'b0);
      n_tests++;
      if (s_ready !== 1'b0 || t_ready !== 1'b0) begin
        n_fail++; $display("FAIL cfg_ready_busy got=%b%b exp=00", s_ready, t_ready);
      end
    end
    in_valid = 1'b0;
    #1;
    n_tests++;
    if (s_ready !== 1'b1) begin
      n_fail++; $display("FAIL cfg_ready_free got=%b exp=1", s_ready);
    end
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    m_mv = 4'b0000; m_pt = 5'b11010; m_ra = 1; m_ai = 0; m_sat = 0;
    n_tests++;
    if (s_sat !== 1'b0 || s_valid !== 1'b0) begin
      n_fail++; $display("FAIL cfg_xfer_sat got=%b/%b exp=0/0", s_sat, s_valid);
    end
    beat(8'd11, 8'd22, 8'd33, 8'd44, 1'b0, 1'b0);
    idle_check();
  endtask

  task automatic test_back_to_back();
    logic [3:0] mvs [4];
    logic [4:0] pts [4];
    mvs[0] = 4'b1111; pts[0] = 5'b00111;
    mvs[1] = 4'b0101; pts[1] = 5'b01100;
    mvs[2] = 4'b1010; pts[2] = 5'b10011;
    mvs[3] = 4'b0011; pts[3] = 5'b00000;
    for (int c = 0; c < 4; c++) begin
      cfg_cycle(mvs[c], pts[c], c[0], c[1]);
      for (int k = 0; k < 10; k++)
        beat(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
             $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0);
    end
    idle_check();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_store();
    test_midstream_reset();
    test_saturate();
    test_auto_inc();
    test_cfg_during_beat();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
